// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD serial adder family: digit width,
// digit type, controller states and the nine's-complement helper used for
// subtraction (BCD_SUB_EN builds).
package bcd_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = bcd_digit_t'(BCD_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nine's complement of a BCD digit; a non-decimal digit (A..F) maps to
  // another non-decimal digit, so validity checking still works afterwards.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_NINE - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One combinational BCD digit cell: x + y + c with decimal correction.
// Also flags either input digit being outside 0..9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t x_i,
  input  bcd_digit_t y_i,
  input  logic       c_i,
  output bcd_digit_t digit_o,
  output logic       carry_o,
  output logic       invalid_o
);

  logic [4:0] rawSum;
  logic [4:0] adjSum;

  // Binary add, then add 6 to wrap any result above nine back into a decimal digit.
  always_comb begin
    rawSum    = {1'b0, x_i} + {1'b0, y_i} + {4'b0000, c_i};
    adjSum    = rawSum + 5'd6;
    digit_o   = rawSum[3:0];
    carry_o   = 1'b0;
    if (rawSum > 5'd9) begin
      digit_o = adjSum[3:0];
      carry_o = 1'b1;
    end
    invalid_o = (x_i > BCD_NINE) || (y_i > BCD_NINE);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder that walks DPC digits per clock, least
// significant first, with ready/valid handshakes on both sides.
// Optional feature macro: BCD_SUB_EN (enables a - b - cin when sub=1).
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DPC    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int SAFE_DPC = (DPC > 0) ? DPC : 1;
  localparam int W        = BCD_W * DIGITS;
  localparam int STEP_W   = BCD_W * SAFE_DPC;
  localparam int CYCLES   = DIGITS / SAFE_DPC;
  localparam int CNT_W    = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES);

  generate
    if ((DIGITS < 1) || (DPC < 1) || ((DIGITS % SAFE_DPC) != 0)) begin : g_bad_cfg
      $fatal(1, "bcd_serial_adder: DPC must be >= 1 and divide DIGITS");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [W-1:0]       aShift_q, aShift_d;
  logic [W-1:0]       bShift_q, bShift_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SAFE_DPC:0]     carryChain;
  logic [STEP_W-1:0]     resDigits;
  logic [SAFE_DPC-1:0]   digitInvalid;
  logic [W+STEP_W-1:0]   sumShift;

`ifdef BCD_SUB_EN
  logic sub_q, sub_d;
`else
  logic unusedSub;
  assign unusedSub = sub;
`endif

  assign carryChain[0] = carry_q;
  assign sumShift      = {resDigits, sum_q};

  // Ripple of DPC digit cells working on the low digits of the shift registers.
  generate
    for (genvar j = 0; j < SAFE_DPC; j++) begin : g_cell
      bcd_digit_t xDig;
      bcd_digit_t yDig;
      assign xDig = aShift_q[j*BCD_W +: BCD_W];
`ifdef BCD_SUB_EN
      assign yDig = sub_q ? nines_comp(bShift_q[j*BCD_W +: BCD_W])
                          : bShift_q[j*BCD_W +: BCD_W];
`else
      assign yDig = bShift_q[j*BCD_W +: BCD_W];
`endif
      bcd_digit_add u_cell (
        .x_i       (xDig),
        .y_i       (yDig),
        .c_i       (carryChain[j]),
        .digit_o   (resDigits[j*BCD_W +: BCD_W]),
        .carry_o   (carryChain[j+1]),
        .invalid_o (digitInvalid[j])
      );
    end
  endgenerate

  // Controller next state: one RUN pass per digit group plus a final settle cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid && in_ready) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST)    state_d = DONE;
      DONE:    if (out_ready)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: capture on accept, shift digits through the cells while running.
  always_comb begin
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
`ifdef BCD_SUB_EN
    sub_d    = sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          aShift_d = a;
          bShift_d = b;
          sum_d    = '0;
          cout_d   = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
`ifdef BCD_SUB_EN
          sub_d    = sub;
          carry_d  = sub ? ~cin : cin;
`else
          carry_d  = cin;
`endif
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          cout_d = carry_q;
        end else begin
          aShift_d = aShift_q >> STEP_W;
          bShift_d = bShift_q >> STEP_W;
          sum_d    = sumShift[W+STEP_W-1:STEP_W];
          carry_d  = carryChain[SAFE_DPC];
          err_d    = err_q | (|digitInvalid);
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      aShift_q <= '0;
      bShift_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef BCD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`ifdef BCD_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule
